dff_sampling_chain: RTL and testbench
=====================================

Name: dff_sampling_chain

Overview:
- Rising-edge D flip-flop chain with an internal sample-strobe generator. Used as the basic storage and delay element of the CPU's shift-register datapath.
- The strobe generator replaces a free-running divided clock. Everything runs on the single system clock, and the flops load only on strobe cycles (no gated clocks).
- Stage 0 is the plain D flip-flop: q follows d one strobe later. Further stages give a DEPTH-strobe delayed tap.

Parameters:
- WIDTH, 1, bit width of d and of every stage.
- DEPTH, 4, number of flop stages in the chain; minimum 1.
- TICK_DIV, 1, strobe period in clk cycles; 1 = sample every cycle; minimum 1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable; when low, the strobe counter and all stages hold.
- d  input  WIDTH  data input to stage 0.
- q  output  WIDTH  stage 0 output (single D flip-flop behaviour).
- q_tap  output  WIDTH  last stage output (d delayed DEPTH strobes).
- tick  output  1  registered strobe; high for exactly one clk cycle per strobe period.

Behaviour:
- Reset (rst=1 at a rising clk edge):
  - All stages clear to 0, so q=0 and q_tap=0.
  - tick_cnt clears to 0 and tick clears to 0.
  - rst has priority over en and over a strobe in the same cycle.
- Reset asserted mid-operation clears on the next rising edge regardless of strobe phase. No asynchronous effect: outputs are unchanged between edges.
- Strobe generator:
  - Internal counter tick_cnt, width clog2(TICK_DIV) (minimum 1 bit).
  - On each enabled edge the counter counts 0..TICK_DIV-1 and wraps to 0.
  - Strobe condition: en=1 and tick_cnt==TICK_DIV-1.
  - With TICK_DIV=1, the strobe equals en every cycle.
  - tick is the strobe condition registered, one cycle late, for observation only.
- Data path, on a rising edge with the strobe condition true and rst=0:
  - stage[0] <= d.
  - stage[k] <= stage[k-1] for k = 1..DEPTH-1.
  - All stages update simultaneously (true shift, no ripple-through).
- Outputs: q = stage[0] and q_tap = stage[DEPTH-1]. With DEPTH=1, q_tap equals q.
- Latency:
  - q reflects d sampled at the last strobe edge: 1 strobe of latency.
  - q_tap has DEPTH strobes of latency.
- d changing between strobe edges has no effect. Only the value present at the strobe edge is captured.
- en=0: counter and stages hold their values, and tick is 0 on the next edge.
- Glitch-free: all outputs are driven directly from flops; no combinational path from d to q.
- No X propagation after the first reset. Before the first reset, outputs are undefined and checkers must ignore them.

Test Plan:
- Reset: hold rst=1 for 2 cycles with d=1 and en=1 -> q=0, q_tap=0, tick=0 after the first edge. Then release rst -> q=1 after the next edge (TICK_DIV=1).
- Basic DFF, TICK_DIV=1, en=1: apply d = bit1 of i for i=0..19 (0,0,1,1,0,0,...), one value per cycle. Required response:
  - q equals the previous cycle's d.
  - q_tap equals d from 4 cycles earlier.
  - Sample points are at every 10 ns check (the bench clock period is 10 ns).
- Mid-cycle d change: toggle d 0->1->0 between two rising edges -> q stays 0; only the value at the edge is captured.
- Strobe division, TICK_DIV=3: tick pulses for one cycle every 3 cycles. q updates only on strobe edges; with d held at 1 from cycle 0, q=1 after the third edge.
- Enable hold: drop en=0 for 5 cycles while d toggles -> q, q_tap and tick_cnt are frozen. On raising en, shifting resumes from the held state.
- Reset mid-shift: assert rst=1 for one cycle while the chain holds 1,0,1,1 -> all stages are 0 on the next edge, and tick_cnt restarts from 0.

Source files
------------

// File: rtl/dff_sampling_chain.sv
// dff_sampling_chain: a chain of rising-edge D flip-flops that load only on
// strobe cycles. The strobe comes from an internal divider running on the
// single system clock, so there is no gated or divided clock anywhere.
// q is the first stage (plain DFF behaviour), q_tap is the last stage
// (d delayed by DEPTH strobes). tick is the strobe, registered, for
// observation only.
module dff_sampling_chain #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_tap,
    output logic             tick
);

    // A divide-by-1 still gets a one-bit counter that simply stays at 0.
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic             strobe;

    assign strobe = en && (tick_cnt_q == CNT_LAST);

    // Divider: advance on every enabled cycle, wrap after the strobe cycle.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (en) begin
            if (strobe) begin
                tick_cnt_d = '0;
            end else begin
                tick_cnt_d = tick_cnt_q + CNT_W'(1);
            end
        end
        tick_d = strobe;
    end

    // Shift: every stage takes its predecessor's old value on a strobe, so
    // data moves exactly one stage per strobe.
    always_comb begin
        stage_d = stage_q;
        if (strobe) begin
            stage_d[0] = d;
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    // State registers; synchronous reset wins over enable and strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign q     = stage_q[0];
    assign q_tap = stage_q[DEPTH-1];
    assign tick  = tick_q;

endmodule

// File: tb/tb_dff_sampling_chain.sv
// Scoreboard bench for dff_sampling_chain. Three instances share rst/en/d:
//   u_div1 : TICK_DIV=1, DEPTH=4
//   u_div3 : TICK_DIV=3, DEPTH=4
//   u_dep1 : TICK_DIV=2, DEPTH=1 (q_tap must equal q)
// The driver applies inputs on the falling edge and pushes the response the
// reference model predicts for the following rising edge; the monitor pops
// and compares just after each rising edge.
module tb_dff_sampling_chain;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] qt;
        logic         t;
    } resp_t;

    typedef resp_t [2:0] trio_t;

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] d;

    logic [W-1:0] q0, qt0, q1, qt1, q2, qt2;
    logic         t0, t1, t2;

    trio_t sb_q [$];

    int checks   = 0;
    int failures = 0;

    // Reference model: strobe count is derived from the number of enabled
    // cycles since reset; history is kept as a plain array of samples.
    int           div_cfg [3] = '{1, 3, 2};
    int           dep_cfg [3] = '{4, 4, 1};
    int           en_cnt  [3];
    logic [W-1:0] hist    [3][4];
    logic         exp_t   [3];

    dff_sampling_chain #(.WIDTH(W), .DEPTH(4), .TICK_DIV(1)) u_div1 (
        .clk(clk), .rst(rst), .en(en), .d(d), .q(q0), .q_tap(qt0), .tick(t0)
    );
    dff_sampling_chain #(.WIDTH(W), .DEPTH(4), .TICK_DIV(3)) u_div3 (
        .clk(clk), .rst(rst), .en(en), .d(d), .q(q1), .q_tap(qt1), .tick(t1)
    );
    dff_sampling_chain #(.WIDTH(W), .DEPTH(1), .TICK_DIV(2)) u_dep1 (
        .clk(clk), .rst(rst), .en(en), .d(d), .q(q2), .q_tap(qt2), .tick(t2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_push(input logic r, input logic e, input logic [W-1:0] dv);
        trio_t exp;
        logic  s;
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                en_cnt[i] = 0;
                exp_t[i]  = 1'b0;
                for (int k = 0; k < 4; k++) hist[i][k] = '0;
            end else begin
                s = e && ((en_cnt[i] % div_cfg[i]) == div_cfg[i] - 1);
                exp_t[i] = s;
                if (e) en_cnt[i] = en_cnt[i] + 1;
                if (s) begin
                    for (int k = dep_cfg[i] - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
                    hist[i][0] = dv;
                end
            end
            exp[i].q  = hist[i][0];
            exp[i].qt = hist[i][dep_cfg[i]-1];
            exp[i].t  = exp_t[i];
        end
        sb_q.push_back(exp);
    endtask

    task automatic step(input logic r, input logic e, input logic [W-1:0] dv);
        @(negedge clk);
        rst = r;
        en  = e;
        d   = dv;
        model_push(r, e, dv);
    endtask

    // d wiggles between edges; only the value settled at the edge counts.
    task automatic glitch_step(input logic [W-1:0] final_d);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        d   = final_d;
        #1 d = ~final_d;
        #1 d = final_d;
        model_push(1'b0, 1'b1, final_d);
    endtask

    // Monitor: compare every instance against the head of the scoreboard.
    initial begin
        trio_t exp;
        trio_t act;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                act[0] = '{q: q0, qt: qt0, t: t0};
                act[1] = '{q: q1, qt: qt1, t: t1};
                act[2] = '{q: q2, qt: qt2, t: t2};
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (act[i] !== exp[i]) begin
                        failures++;
                        $display("FAIL dut%0d t=%0t q/q_tap/tick got %h/%h/%b want %h/%h/%b",
                                 i, $time, act[i].q, act[i].qt, act[i].t,
                                 exp[i].q, exp[i].qt, exp[i].t);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            en_cnt[i] = 0;
            exp_t[i]  = 1'b0;
            for (int k = 0; k < 4; k++) hist[i][k] = '0;
        end
        rst = 1'b1;
        en  = 1'b1;
        d   = 4'h1;

        // Reset held for two edges with d=1, en=1, then release.
        step(1'b1, 1'b1, 4'h1);
        step(1'b0, 1'b1, 4'h1);

        // Basic DFF / tap pattern 0,0,1,1,0,0,...
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, W'((i >> 1) & 1));

        // Mid-cycle changes on d must not be captured.
        glitch_step(4'h0);
        glitch_step(4'h0);
        glitch_step(4'h1);

        // Divide-by-3: reset then hold d=1.
        step(1'b1, 1'b1, 4'h0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 4'h1);

        // Enable hold with d toggling, then resume.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, W'($urandom));
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, W'($urandom));

        // Load chain with 1,0,1,1 (stage0..3) then reset mid-shift.
        step(1'b0, 1'b1, 4'h1);
        step(1'b0, 1'b1, 4'h1);
        step(1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b1, 4'h1);
        step(1'b1, 1'b1, 4'hF);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, W'($urandom));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 8), W'($urandom));
        end

        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
